// File: rtl/rst_seq.sv
// rst_seq: staggered reset-release sequencer with a four-phase soft-reset handshake.
// One global reset releases NUM_STAGES reset domains in ascending order,
// with STAGE_DELAY cycles between consecutive releases. A soft-reset
// request re-runs the full sequence without asserting the global reset.
//
// Ports:
//   clk_i           reference clock
//   rst_i           async active-high global reset (deassertion synchronized inside)
//   soft_rst_req_i  soft-reset request, four-phase level
//   soft_rst_ack_o  soft-reset acknowledge, four-phase level
//   rst_o           per-stage active-high reset, bit k is stage k
//   rst_no          bitwise inverse of rst_o
//   seq_done_o      high once every stage is released
//   state_o         FSM state for debug: HOLD=0, RELEASE=1, DONE=2, SOFT=3
module rst_seq #(
    parameter int unsigned NUM_STAGES      = 4,
    parameter int unsigned STAGE_DELAY     = 8,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned SOFT_RST_CYCLES = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  soft_rst_req_i,
    output logic                  soft_rst_ack_o,
    output logic [NUM_STAGES-1:0] rst_o,
    output logic [NUM_STAGES-1:0] rst_no,
    output logic                  seq_done_o,
    output logic [1:0]            state_o
);

    localparam int unsigned CNT_MAX = (STAGE_DELAY > SOFT_RST_CYCLES) ? STAGE_DELAY : SOFT_RST_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned STG_W   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_RELEASE = 2'd1,
        S_DONE    = 2'd2,
        S_SOFT    = 2'd3
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_e                 state_q, state_d;
    logic [STG_W-1:0]       stage_q, stage_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_STAGES-1:0]  rst_q, rst_d;
    logic                   done_q, done_d;
    logic                   ack_q, ack_d;
    // Marks a sequence that was started by a soft request, so only that one is acknowledged.
    logic                   soft_q, soft_d;

    // State register; rst_i sets everything to the reset values immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q  <= '1;
            state_q <= S_HOLD;
            stage_q <= '0;
            cnt_q   <= '0;
            rst_q   <= '1;
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
            soft_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            stage_q <= stage_d;
            cnt_q   <= cnt_d;
            rst_q   <= rst_d;
            done_q  <= done_d;
            ack_q   <= ack_d;
            soft_q  <= soft_d;
        end
    end

    // Next-state, counter, stage and output logic.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], 1'b0};
        state_d = state_q;
        stage_d = stage_q;
        cnt_d   = cnt_q;
        rst_d   = rst_q;
        done_d  = done_q;
        ack_d   = ack_q & soft_rst_req_i;
        soft_d  = soft_q;

        case (state_q)
            S_HOLD: begin
                // Leave on the edge where the synchronizer output deasserts, so the
                // release schedule is anchored at edge SYNC_STAGES.
                if (!sync_d[SYNC_STAGES-1]) begin
                    state_d = S_RELEASE;
                    stage_d = '0;
                    cnt_d   = '0;
                end
            end
            S_RELEASE: begin
                if (cnt_q == CNT_W'(STAGE_DELAY - 1)) begin
                    for (int unsigned k = 0; k < NUM_STAGES; k++) begin
                        if (STG_W'(k) == stage_q) begin
                            rst_d[k] = 1'b0;
                        end
                    end
                    cnt_d = '0;
                    if (stage_q == STG_W'(NUM_STAGES - 1)) begin
                        state_d = S_DONE;
                        stage_d = '0;
                        done_d  = 1'b1;
                        if (soft_q) begin
                            ack_d  = 1'b1;
                            soft_d = 1'b0;
                        end
                    end else begin
                        stage_d = stage_q + STG_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                // A request still held after its ack is not a new request.
                if (soft_rst_req_i && !ack_q) begin
                    state_d = S_SOFT;
                    cnt_d   = '0;
                    rst_d   = '1;
                    done_d  = 1'b0;
                    soft_d  = 1'b1;
                end
            end
            S_SOFT: begin
                if (cnt_q == CNT_W'(SOFT_RST_CYCLES - 1)) begin
                    state_d = S_RELEASE;
                    stage_d = '0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_HOLD;
            end
        endcase
    end

    assign rst_o          = rst_q;
    assign rst_no         = ~rst_q;
    assign seq_done_o     = done_q;
    assign soft_rst_ack_o = ack_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: scoreboard bench for rst_seq. A reference model computes the expected
// outputs after every clock edge from the release schedule (edge arithmetic) and
// pushes them into a queue; a monitor pops and compares one entry per edge.
// Directed scenarios add edge-count and asynchronous-reset checks; a second instance
// with NUM_STAGES=1, STAGE_DELAY=1 checks the short-sequence corner.
module tb_rst_seq;

    localparam int N   = 4;
    localparam int D   = 8;
    localparam int SY  = 2;
    localparam int SC  = 16;
    localparam int BIG = 1 << 30;

    logic         clk   = 1'b0;
    logic         rst_a = 1'b0;
    logic         req   = 1'b0;

    logic         ack_a, done_a;
    logic [N-1:0] rst_oa, rst_noa;
    logic [1:0]   st_a;

    logic         ack_b, done_b;
    logic [0:0]   rst_ob, rst_nob;
    logic [1:0]   st_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rst_seq #(
        .NUM_STAGES      (N),
        .STAGE_DELAY     (D),
        .SYNC_STAGES     (SY),
        .SOFT_RST_CYCLES (SC)
    ) dut_a (
        .clk_i          (clk),
        .rst_i          (rst_a),
        .soft_rst_req_i (req),
        .soft_rst_ack_o (ack_a),
        .rst_o          (rst_oa),
        .rst_no         (rst_noa),
        .seq_done_o     (done_a),
        .state_o        (st_a)
    );

    rst_seq #(
        .NUM_STAGES      (1),
        .STAGE_DELAY     (1),
        .SYNC_STAGES     (2),
        .SOFT_RST_CYCLES (16)
    ) dut_b (
        .clk_i          (clk),
        .rst_i          (rst_a),
        .soft_rst_req_i (1'b0),
        .soft_rst_ack_o (ack_b),
        .rst_o          (rst_ob),
        .rst_no         (rst_nob),
        .seq_done_o     (done_b),
        .state_o        (st_b)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_reset(input string name);
        chk({name, "_rst_o"},  32'(rst_oa),  32'hF);
        chk({name, "_rst_no"}, 32'(rst_noa), 32'h0);
        chk({name, "_done"},   32'(done_a),  32'h0);
        chk({name, "_ack"},    32'(ack_a),   32'h0);
        chk({name, "_state"},  32'(st_a),    32'h0);
    endtask

    // ---------------- reference model ----------------
    int         n         = 0;
    int         rel_start = BIG;
    bit         in_soft   = 1'b0;
    bit         soft_flag = 1'b0;
    bit         m_ack     = 1'b0;
    logic [1:0] m_state   = 2'd0;
    bit         rst_seen  = 1'b0;
    logic [11:0] exp_q[$];

    always @(posedge rst_a) rst_seen = 1'b1;

    always @(posedge clk) begin : model
        logic [N-1:0] e_rst;
        logic         e_done;
        logic [1:0]   e_state;
        bit           new_ack;
        n++;
        if (rst_a || rst_seen) begin
            // Reset active now, or a reset happened since the last edge.
            rel_start = rst_a ? BIG : n + SY - 1;
            if (!rst_a) rst_seen = 1'b0;
            in_soft   = 1'b0;
            soft_flag = 1'b0;
            m_ack     = 1'b0;
            m_state   = 2'd0;
        end else if (m_state == 2'd2 && req && !m_ack) begin
            rel_start = n + SC;
            in_soft   = 1'b1;
            soft_flag = 1'b1;
        end
        new_ack = m_ack && req;
        if (n < rel_start) begin
            e_rst   = '1;
            e_done  = 1'b0;
            e_state = in_soft ? 2'd3 : 2'd0;
        end else begin
            in_soft = 1'b0;
            for (int k = 0; k < N; k++) e_rst[k] = (n < rel_start + (k + 1) * D);
            e_done  = (n >= rel_start + N * D);
            e_state = e_done ? 2'd2 : 2'd1;
            if (soft_flag && n == rel_start + N * D) begin
                new_ack   = 1'b1;
                soft_flag = 1'b0;
            end
        end
        m_ack   = new_ack;
        m_state = e_state;
        exp_q.push_back({e_rst, ~e_rst, e_done, m_ack, e_state});
    end

    // ---------------- monitor ----------------
    always @(posedge clk) begin : monitor
        logic [11:0] e;
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: no expected entry at t=%0t", $time);
        end else begin
            e = exp_q.pop_front();
            chk("scoreboard", 32'({rst_oa, rst_noa, done_a, ack_a, st_a}), 32'(e));
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got t=%0t required < 100000", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int first_done_a, first_done_b, e, e_soft, e_rel0;

        // Power-on reset.
        #1 rst_a = 1'b1;
        #1 chk_reset("por_async");
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0;
        first_done_a = 0;
        first_done_b = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #2;
            if (i == 1) chk("por_state_hold", 32'(st_a), 32'h0);
            if (i == 9) chk("por_rst_before_rel0", 32'(rst_oa), 32'hF);
            if (done_a && first_done_a == 0) first_done_a = i;
            if (done_b && first_done_b == 0) first_done_b = i;
        end
        chk("por_done_edge", 32'(first_done_a), 32'd34);
        chk("one_stage_done_edge", 32'(first_done_b), 32'd3);
        chk("one_stage_outputs", 32'({rst_ob, rst_nob, st_b}), 32'b0110);

        // Soft reset held high through the ack.
        repeat ($urandom_range(1, 6)) @(negedge clk);
        req = 1'b1;
        @(posedge clk);
        #2;
        chk("soft_entry_rst", 32'(rst_oa), 32'hF);
        chk("soft_entry_state", 32'(st_a), 32'h3);
        e = 0;
        while (!ack_a && e < 100) begin
            @(posedge clk);
            #2;
            e++;
        end
        chk("soft_ack_edge", 32'(e), 32'd48);
        repeat (20) @(posedge clk);
        #2;
        chk("no_retrigger_state", 32'(st_a), 32'h2);
        chk("no_retrigger_ack", 32'(ack_a), 32'h1);
        @(negedge clk);
        req = 1'b0;
        @(posedge clk);
        #2;
        chk("ack_clear", 32'(ack_a), 32'h0);

        // Mid-sequence global reset, then an early soft request on the restart.
        @(negedge clk);
        rst_a = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0;
        repeat (20) @(posedge clk);
        #3;
        chk("pre_midrst_rst", 32'(rst_oa), 32'hC);
        rst_a = 1'b1;
        #1 chk_reset("midseq_async");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0;
        first_done_a = 0;
        e_soft = 0;
        e_rel0 = 0;
        for (int i = 1; i <= 120; i++) begin
            @(posedge clk);
            #2;
            if (done_a && first_done_a == 0) first_done_a = i;
            if (st_a == 2'd3 && e_soft == 0) e_soft = i;
            if (e_soft != 0 && !rst_oa[0] && e_rel0 == 0) e_rel0 = i;
            if (i == 11) begin
                @(negedge clk);
                req = 1'b1;
            end
        end
        chk("restart_done_edge", 32'(first_done_a), 32'd34);
        chk("early_req_soft_edge", 32'(e_soft), 32'd35);
        chk("early_req_rel0_edge", 32'(e_rel0), 32'd59);
        chk("early_req_ack", 32'(ack_a), 32'h1);
        @(negedge clk);
        req = 1'b0;
        repeat (4) @(negedge clk);

        // Sub-cycle reset glitch while in DONE.
        rst_a = 1'b1;
        #3 rst_a = 1'b0;
        #1 chk_reset("glitch_async");
        first_done_a = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #2;
            if (done_a && first_done_a == 0) first_done_a = i;
        end
        chk("glitch_done_edge", 32'(first_done_a), 32'd34);

        // Random request pulses and occasional reset glitches.
        for (int it = 0; it < 8; it++) begin
            repeat ($urandom_range(1, 30)) @(negedge clk);
            req = 1'b1;
            repeat ($urandom_range(1, 80)) @(negedge clk);
            req = 1'b0;
            if ($urandom_range(0, 2) == 0) begin
                @(negedge clk);
                rst_a = 1'b1;
                #($urandom_range(1, 3)) rst_a = 1'b0;
            end
        end

        // Let the last sequence complete.
        repeat (120) @(negedge clk);
        chk("final_done", 32'(done_a), 32'h1);
        chk("final_ack", 32'(ack_a), 32'h0);
        chk("final_rst", 32'({rst_oa, rst_noa}), 32'h0F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
